// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//   Conditions the four board push-buttons (1=up, 2=left, 3=right, 4=down).
//   Each raw switch passes through a two-flop synchroniser. A per-channel
//   counter then only accepts a new level once it has persisted for
//   DEBOUNCE_CYCLES consecutive clock edges. The accepted level is presented
//   as a clean registered output. A one-cycle press or release pulse is
//   emitted on the same edge that the accepted level changes.
//
// Ports
//   clock               in   1  system clock, rising edge
//   reset_n             in   1  asynchronous active-low reset
//   i_switch_1..4       in   1  raw switch levels (1 = pressed), asynchronous
//   switch_stable_1..4  out  1  debounced level per switch
//   o_press_pulse       out  4  bit k-1: one-cycle pulse on switch k 0->1
//   o_release_pulse     out  4  bit k-1: one-cycle pulse on switch k 1->0
// -----------------------------------------------------------------------------
module switch_debouncer #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_WIDTH       = 18
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       i_switch_1,
   input  logic       i_switch_2,
   input  logic       i_switch_3,
   input  logic       i_switch_4,
   output logic       switch_stable_1,
   output logic       switch_stable_2,
   output logic       switch_stable_3,
   output logic       switch_stable_4,
   output logic [3:0] o_press_pulse,
   output logic [3:0] o_release_pulse
);

   localparam int                   NUM_CH  = 4;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [NUM_CH-1:0]    raw_s;
   logic [NUM_CH-1:0]    sync1_r;
   logic [NUM_CH-1:0]    sync2_r;
   logic [NUM_CH-1:0]    stable_r;
   logic [NUM_CH-1:0]    press_r;
   logic [NUM_CH-1:0]    release_r;
   logic [CNT_WIDTH-1:0] cnt_r [NUM_CH];

   logic [NUM_CH-1:0]    stable_nxt_s;
   logic [NUM_CH-1:0]    press_nxt_s;
   logic [NUM_CH-1:0]    release_nxt_s;
   logic [CNT_WIDTH-1:0] cnt_nxt_s [NUM_CH];

   assign raw_s = {i_switch_4, i_switch_3, i_switch_2, i_switch_1};

   // Per-channel debounce decision: count mismatches, accept at terminal count.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         cnt_nxt_s[k]     = '0;
         stable_nxt_s[k]  = stable_r[k];
         press_nxt_s[k]   = 1'b0;
         release_nxt_s[k] = 1'b0;
         if (sync2_r[k] == stable_r[k]) begin
            // Agreement (or a bounce back) discards any partial count.
            cnt_nxt_s[k] = '0;
         end else if (cnt_r[k] >= CNT_MAX) begin
            // >= rather than == so a corrupted count still resolves at once.
            stable_nxt_s[k]  = sync2_r[k];
            press_nxt_s[k]   = sync2_r[k];
            release_nxt_s[k] = ~sync2_r[k];
            cnt_nxt_s[k]     = '0;
         end else begin
            cnt_nxt_s[k] = cnt_r[k] + CNT_ONE;
         end
      end
   end

   // Synchroniser, counters, accepted levels and edge pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r   <= 4'b0000;
         sync2_r   <= 4'b0000;
         stable_r  <= 4'b0000;
         press_r   <= 4'b0000;
         release_r <= 4'b0000;
         for (int k = 0; k < NUM_CH; k++) begin
            cnt_r[k] <= '0;
         end
      end else begin
         sync1_r   <= raw_s;
         sync2_r   <= sync1_r;
         stable_r  <= stable_nxt_s;
         press_r   <= press_nxt_s;
         release_r <= release_nxt_s;
         for (int k = 0; k < NUM_CH; k++) begin
            cnt_r[k] <= cnt_nxt_s[k];
         end
      end
   end

   assign switch_stable_1 = stable_r[0];
   assign switch_stable_2 = stable_r[1];
   assign switch_stable_3 = stable_r[2];
   assign switch_stable_4 = stable_r[3];
   assign o_press_pulse   = press_r;
   assign o_release_pulse = release_r;

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//   Table-driven bench for switch_debouncer with DEBOUNCE_CYCLES=4, CNT_WIDTH=3.
//   Each table row is one clock cycle: the inputs driven before the edge and
//   the outputs expected just after it. Expected rows go through a scoreboard
//   queue and are popped when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       i_switch_1, i_switch_2, i_switch_3, i_switch_4;
   logic       switch_stable_1, switch_stable_2, switch_stable_3, switch_stable_4;
   logic [3:0] o_press_pulse;
   logic [3:0] o_release_pulse;
   logic [3:0] act_st;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string      name;
      logic       rst_n;
      logic [3:0] raw;
      logic [3:0] st;
      logic [3:0] pr;
      logic [3:0] rl;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   always #5 clock = ~clock;

   switch_debouncer #(
      .DEBOUNCE_CYCLES(4),
      .CNT_WIDTH      (3)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .i_switch_1     (i_switch_1),
      .i_switch_2     (i_switch_2),
      .i_switch_3     (i_switch_3),
      .i_switch_4     (i_switch_4),
      .switch_stable_1(switch_stable_1),
      .switch_stable_2(switch_stable_2),
      .switch_stable_3(switch_stable_3),
      .switch_stable_4(switch_stable_4),
      .o_press_pulse  (o_press_pulse),
      .o_release_pulse(o_release_pulse)
   );

   assign act_st = {switch_stable_4, switch_stable_3, switch_stable_2, switch_stable_1};

   function automatic void add(input string nm, input logic r, input logic [3:0] raw,
                               input logic [3:0] st, input logic [3:0] pr, input logic [3:0] rl);
      vec_t v;
      v.name  = nm;
      v.rst_n = r;
      v.raw   = raw;
      v.st    = st;
      v.pr    = pr;
      v.rl    = rl;
      tbl.push_back(v);
   endfunction

   function automatic void add_n(input int n, input string nm, input logic r, input logic [3:0] raw,
                                 input logic [3:0] st, input logic [3:0] pr, input logic [3:0] rl);
      for (int i = 0; i < n; i++) add(nm, r, raw, st, pr, rl);
   endfunction

   task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: stable/press/release got %b_%b_%b want %b_%b_%b", nm, $time,
                  act[11:8], act[7:4], act[3:0], exp[11:8], exp[7:4], exp[3:0]);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] raw);
      reset_n    = r;
      i_switch_1 = raw[0];
      i_switch_2 = raw[1];
      i_switch_3 = raw[2];
      i_switch_4 = raw[3];
   endtask

   initial begin
      vec_t       v;
      logic       prev_rst;
      logic [3:0] pulse_acc;

      drive(1'b0, 4'b0000);

      // Reset state
      add_n(3, "reset",        1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      // 1: raw_1 held -> accept on 6th edge, one press pulse, no auto-repeat
      add_n(5, "t1_wait",      1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      add  (   "t1_press",     1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
      add_n(4, "t1_hold",      1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      // 2: raw_2 bounces 1,0,1,0 (2 cycles each) then held 1
      add_n(2, "t2_bounce",    1'b1, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
      add_n(2, "t2_bounce",    1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add_n(2, "t2_bounce",    1'b1, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
      add_n(2, "t2_bounce",    1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add_n(5, "t2_wait",      1'b1, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
      add  (   "t2_press",     1'b1, 4'b0011, 4'b0011, 4'b0010, 4'b0000);
      add_n(2, "t2_hold",      1'b1, 4'b0011, 4'b0011, 4'b0000, 4'b0000);
      // 3: set stable_3, then release it
      add_n(5, "t3_set_wait",  1'b1, 4'b0111, 4'b0011, 4'b0000, 4'b0000);
      add  (   "t3_set_press", 1'b1, 4'b0111, 4'b0111, 4'b0100, 4'b0000);
      add  (   "t3_set_hold",  1'b1, 4'b0111, 4'b0111, 4'b0000, 4'b0000);
      add_n(5, "t3_rel_wait",  1'b1, 4'b0011, 4'b0111, 4'b0000, 4'b0000);
      add  (   "t3_release",   1'b1, 4'b0011, 4'b0011, 4'b0000, 4'b0100);
      add  (   "t3_after",     1'b1, 4'b0011, 4'b0011, 4'b0000, 4'b0000);
      // 4: simultaneous release of 1,2 then simultaneous press of 1,4
      add_n(5, "t4_rel_wait",  1'b1, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
      add  (   "t4_release",   1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0011);
      add  (   "t4_idle",      1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add_n(5, "t4_wait",      1'b1, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
      add  (   "t4_press",     1'b1, 4'b1001, 4'b1001, 4'b1001, 4'b0000);
      add  (   "t4_hold",      1'b1, 4'b1001, 4'b1001, 4'b0000, 4'b0000);
      // 5: raw_2 counting to 2, reset, then full re-acceptance of all held switches
      add_n(4, "t5_count",     1'b1, 4'b1011, 4'b1001, 4'b0000, 4'b0000);
      add_n(2, "t5_in_reset",  1'b0, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
      add_n(5, "t5_wait",      1'b1, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
      add  (   "t5_press",     1'b1, 4'b1011, 4'b1011, 4'b1011, 4'b0000);
      add  (   "t5_hold",      1'b1, 4'b1011, 4'b1011, 4'b0000, 4'b0000);
      // 6: 3-cycle low glitch on switch 4 -> nothing changes
      add_n(3, "t6_glitch",    1'b1, 4'b0011, 4'b1011, 4'b0000, 4'b0000);
      add_n(6, "t6_after",     1'b1, 4'b1011, 4'b1011, 4'b0000, 4'b0000);

      prev_rst = 1'b0;
      foreach (tbl[i]) begin
         @(negedge clock);
         drive(tbl[i].rst_n, tbl[i].raw);
         if (prev_rst && !tbl[i].rst_n) begin
            // Reset must clear outputs with no clock edge in between
            #1;
            check({tbl[i].name, "_async"}, {act_st, o_press_pulse, o_release_pulse}, 12'h000);
         end
         prev_rst = tbl[i].rst_n;
         exp_q.push_back(tbl[i]);
         @(posedge clock);
         #1;
         v = exp_q.pop_front();
         check(v.name, {act_st, o_press_pulse, o_release_pulse}, {v.st, v.pr, v.rl});
      end

      // Long hold: no auto-repeat pulses, level stays put
      pulse_acc = 4'b0000;
      for (int c = 0; c < 20; c++) begin
         @(posedge clock);
         #1;
         pulse_acc = pulse_acc | o_press_pulse | o_release_pulse;
      end
      check("long_hold", {act_st, pulse_acc, 4'b0000}, {4'b1011, 4'b0000, 4'b0000});

      // Reset while levels are stable clears them at once
      @(negedge clock);
      drive(1'b0, 4'b1011);
      #1;
      check("final_async_reset", {act_st, o_press_pulse, o_release_pulse}, 12'h000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
